alu_exec_unit: RTL and testbench

- 32-bit integer execution unit for the processor datapath; computes one result per accepted operation from SrcA, SrcB and a 3-bit ALUControl code.
- Operands are sampled on a clock edge and the result is registered, giving fixed 1-cycle latency.
- Sits between the register-read/decode stage and writeback.

---
 rtl/alu_exec_unit_if.sv | 34 +++
 rtl/alu_exec_unit.sv | 137 +++++++++++++
 tb/tb_alu_exec_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operand/result bus of the integer execution unit.
// Zero/Overflow flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_exec_unit_if #(
   parameter int nBits = 32
);
   logic             InValid;
   logic [2:0]       ALUControl;
   logic [nBits-1:0] SrcA;
   logic [nBits-1:0] SrcB;
   logic [nBits-1:0] ALUResult;
   logic             OutValid;
`ifdef ALU_FLAGS_EN
   logic             Zero;
   logic             Overflow;

   modport master (
      output InValid, ALUControl, SrcA, SrcB,
      input  ALUResult, OutValid, Zero, Overflow
   );
   modport slave (
      input  InValid, ALUControl, SrcA, SrcB,
      output ALUResult, OutValid, Zero, Overflow
   );
`else
   modport master (
      output InValid, ALUControl, SrcA, SrcB,
      input  ALUResult, OutValid
   );
   modport slave (
      input  InValid, ALUControl, SrcA, SrcB,
      output ALUResult, OutValid
   );
`endif
endinterface

// File: rtl/alu_exec_unit.sv
// 32-bit integer execution unit with a registered result and fixed 1-cycle latency.
// Optional registered Zero/Overflow flags are enabled by defining ALU_FLAGS_EN.
module alu_exec_unit #(
   parameter int nBits = 32
) (
   input logic            clk,
   input logic            reset,
   alu_exec_unit_if.slave bus
);
   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_MUL  = 3'b001,
      OP_SLT  = 3'b010,
      OP_SUB  = 3'b011,
      OP_AND  = 3'b100,
      OP_OR   = 3'b101,
      OP_XOR  = 3'b110,
      OP_SLTU = 3'b111
   } alu_op_e;

   alu_op_e          op_s;
   logic [nBits-1:0] a_s;
   logic [nBits-1:0] b_s;
   logic [nBits-1:0] sum_s;
   logic [nBits-1:0] diff_s;
   logic [nBits-1:0] mul_lo_s;
   logic             slt_s;
   logic             sltu_s;
   logic [nBits-1:0] alu_s;
   logic [nBits-1:0] result_d;
   logic [nBits-1:0] result_q;
   logic             valid_d;
   logic             valid_q;
`ifdef ALU_FLAGS_EN
   // The full signed product is only needed to detect MUL overflow.
   logic [2*nBits-1:0] prod_s;
   logic               ovf_s;
   logic               zero_d;
   logic               zero_q;
   logic               ovf_d;
   logic               ovf_q;
`endif

   // Operation datapath: all candidate results, then the opcode select.
   always_comb begin
      op_s   = alu_op_e'(bus.ALUControl);
      a_s    = bus.SrcA;
      b_s    = bus.SrcB;
      sum_s  = a_s + b_s;
      diff_s = a_s - b_s;
`ifdef ALU_FLAGS_EN
      prod_s   = {{nBits{a_s[nBits-1]}}, a_s} * {{nBits{b_s[nBits-1]}}, b_s};
      mul_lo_s = prod_s[nBits-1:0];
`else
      mul_lo_s = a_s * b_s;
`endif
      slt_s  = $signed(a_s) < $signed(b_s);
      sltu_s = a_s < b_s;
      alu_s  = '0;
      case (op_s)
         OP_ADD:  alu_s = sum_s;
         OP_MUL:  alu_s = mul_lo_s;
         OP_SLT:  alu_s = {{(nBits-1){1'b0}}, slt_s};
         OP_SUB:  alu_s = diff_s;
         OP_AND:  alu_s = a_s & b_s;
         OP_OR:   alu_s = a_s | b_s;
         OP_XOR:  alu_s = a_s ^ b_s;
         OP_SLTU: alu_s = {{(nBits-1){1'b0}}, sltu_s};
         default: alu_s = '0;
      endcase
   end

   // Result register next state: load on an accepted op, otherwise hold.
   always_comb begin
      valid_d  = bus.InValid;
      result_d = result_q;
      if (bus.InValid) begin
         result_d = alu_s;
      end else begin
         result_d = result_q;
      end
   end

   // Result and valid registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.ALUResult = result_q;
   assign bus.OutValid  = valid_q;

`ifdef ALU_FLAGS_EN
   // Signed overflow: ADD/SUB by sign rule, MUL when the high half is not a sign extension.
   always_comb begin
      ovf_s = 1'b0;
      case (op_s)
         OP_ADD:  ovf_s = (a_s[nBits-1] == b_s[nBits-1]) && (sum_s[nBits-1] != a_s[nBits-1]);
         OP_SUB:  ovf_s = (a_s[nBits-1] != b_s[nBits-1]) && (diff_s[nBits-1] != a_s[nBits-1]);
         OP_MUL:  ovf_s = !((&prod_s[2*nBits-1:nBits-1]) || !(|prod_s[2*nBits-1:nBits-1]));
         default: ovf_s = 1'b0;
      endcase
   end

   // Flag register next state follows the result register.
   always_comb begin
      zero_d = zero_q;
      ovf_d  = ovf_q;
      if (bus.InValid) begin
         zero_d = (alu_s == '0);
         ovf_d  = ovf_s;
      end else begin
         zero_d = zero_q;
         ovf_d  = ovf_q;
      end
   end

   // Flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.Zero     = zero_q;
   assign bus.Overflow = ovf_q;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; inputs change on the falling
// edge, outputs are sampled 1 time unit after the rising edge.
module tb_alu_exec_unit;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   alu_exec_unit_if #(.nBits(32)) bus ();

   alu_exec_unit #(.nBits(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.InValid    = 1'b1;
      bus.ALUControl = op;
      bus.SrcA       = a;
      bus.SrcB       = b;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.InValid    = 1'b0;
      bus.ALUControl = 3'($urandom);
      bus.SrcA       = $urandom;
      bus.SrcB       = $urandom;
   endtask

   task automatic expect_result(input string tag, input logic [31:0] exp);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, {31'd0, bus.OutValid}, 32'd1);
      check(tag, bus.ALUResult, exp);
   endtask

   task automatic expect_idle(input string tag, input logic [31:0] held);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, {31'd0, bus.OutValid}, 32'd0);
      check(tag, bus.ALUResult, held);
   endtask

`ifdef ALU_FLAGS_EN
   task automatic check_flags(input string tag, input logic z, input logic o);
      check({tag, "_zero"}, {31'd0, bus.Zero}, {31'd0, z});
      check({tag, "_ovf"}, {31'd0, bus.Overflow}, {31'd0, o});
   endtask
`endif

   initial begin
      checks         = 0;
      errors         = 0;
      reset          = 1'b1;
      bus.InValid    = 1'b0;
      bus.ALUControl = 3'b000;
      bus.SrcA       = 32'd0;
      bus.SrcB       = 32'd0;
      #1;
      check("rst_result", bus.ALUResult, 32'd0);
      check("rst_valid", {31'd0, bus.OutValid}, 32'd0);

      @(negedge clk);
      reset = 1'b0;
      expect_idle("post_rst_idle", 32'd0);

      // Asynchronous reset in the middle of a cycle with an op in flight.
      drive(3'b000, 32'd2, 32'd3);
      expect_result("pre_rst_add", 32'd5);
      drive(3'b000, 32'd7, 32'd7);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_result", bus.ALUResult, 32'd0);
      check("async_rst_valid", {31'd0, bus.OutValid}, 32'd0);
      @(posedge clk);
      #1;
      check("rst_held_result", bus.ALUResult, 32'd0);
      check("rst_held_valid", {31'd0, bus.OutValid}, 32'd0);
      idle();
      reset = 1'b0;
      expect_idle("rst_release_idle", 32'd0);
      expect_idle("rst_release_idle2", 32'd0);

      // ADD
      drive(3'b000, 32'd0, 32'd1);
      expect_result("add_0_1", 32'd1);
      drive(3'b000, 32'd0, 32'hFFFF_FFFF);
      expect_result("add_0_m1", 32'hFFFF_FFFF);
      drive(3'b000, 32'hFFFF_FFFF, 32'd1);
      expect_result("add_wrap", 32'd0);
      idle();
      expect_idle("hold_after_add", 32'd0);

      // MUL
      drive(3'b001, 32'd0, 32'd1);
      expect_result("mul_0_1", 32'd0);
      drive(3'b001, 32'd1, 32'd1);
      expect_result("mul_1_1", 32'd1);
      drive(3'b001, 32'd1, 32'hFFFF_FFFF);
      expect_result("mul_1_m1", 32'hFFFF_FFFF);
      drive(3'b001, 32'h0001_0000, 32'h0001_0000);
      expect_result("mul_wrap", 32'd0);
`ifdef ALU_FLAGS_EN
      check_flags("mul_wrap", 1'b1, 1'b1);
`endif
      drive(3'b001, 32'd6, 32'd7);
      expect_result("mul_6_7", 32'd42);
      idle();
      expect_idle("hold_after_mul", 32'd42);

      // SLT / SLTU
      drive(3'b010, 32'd1, 32'd0);
      expect_result("slt_1_0", 32'd0);
      drive(3'b010, 32'hFFFF_FFFF, 32'd0);
      expect_result("slt_m1_0", 32'd1);
      drive(3'b010, 32'h8000_0000, 32'h7FFF_FFFF);
      expect_result("slt_min_max", 32'd1);
      drive(3'b111, 32'h8000_0000, 32'h7FFF_FFFF);
      expect_result("sltu_min_max", 32'd0);
      drive(3'b111, 32'hFFFF_FFFF, 32'd0);
      expect_result("sltu_max_0", 32'd0);
      drive(3'b111, 32'd0, 32'hFFFF_FFFF);
      expect_result("sltu_0_max", 32'd1);
      drive(3'b010, 32'h1234_5678, 32'h1234_5678);
      expect_result("slt_equal", 32'd0);
      drive(3'b111, 32'h1234_5678, 32'h1234_5678);
      expect_result("sltu_equal", 32'd0);

      // SUB and logic ops issued back to back.
      drive(3'b011, 32'd5, 32'd7);
      expect_result("sub_5_7", 32'hFFFF_FFFE);
      drive(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00);
      expect_result("and", 32'hF000_F000);
      drive(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00);
      expect_result("or", 32'hFFF0_FFF0);
      drive(3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00);
      expect_result("xor", 32'h0FF0_0FF0);
      idle();
      expect_idle("hold_after_xor", 32'h0FF0_0FF0);
      idle();
      expect_idle("hold_after_xor2", 32'h0FF0_0FF0);

`ifdef ALU_FLAGS_EN
      drive(3'b000, 32'h7FFF_FFFF, 32'd1);
      expect_result("add_ovf", 32'h8000_0000);
      check_flags("add_ovf", 1'b0, 1'b1);
      drive(3'b011, 32'd3, 32'd3);
      expect_result("sub_zero", 32'd0);
      check_flags("sub_zero", 1'b1, 1'b0);
      drive(3'b011, 32'h8000_0000, 32'd1);
      expect_result("sub_ovf", 32'h7FFF_FFFF);
      check_flags("sub_ovf", 1'b0, 1'b1);
      drive(3'b101, 32'd0, 32'd0);
      expect_result("or_zero", 32'd0);
      check_flags("or_zero", 1'b1, 1'b0);
      idle();
      expect_idle("flags_idle", 32'd0);
      check_flags("flags_idle", 1'b1, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
